// File: rtl/downcounter_4_bit_sync_if.sv
// Control/status bundle for the synchronous 4-bit down counter.
// The master drives the controls and load value.
// The slave (the counter) returns the per-bit true/complement outputs plus tc/bo.
interface downcounter_4_bit_sync_if;
    logic       pre;
    logic       load;
    logic [3:0] d;
    logic       en;
    logic       auto_reload;
    logic       Q0, Q1, Q2, Q3;
    logic       Q0_bar, Q1_bar, Q2_bar, Q3_bar;
    logic       tc;
    logic       bo;

    modport master (
        output pre, load, d, en, auto_reload,
        input  Q0, Q1, Q2, Q3, Q0_bar, Q1_bar, Q2_bar, Q3_bar, tc, bo
    );

    modport slave (
        input  pre, load, d, en, auto_reload,
        output Q0, Q1, Q2, Q3, Q0_bar, Q1_bar, Q2_bar, Q3_bar, tc, bo
    );
endinterface

// File: rtl/downcounter_4_bit_sync.sv
// Synchronous 4-bit modulo-MOD down counter.
// Features: preset, saturating parallel load into a reload register,
// optional auto-reload on underflow, and terminal-count/borrow outputs for cascading.
module downcounter_4_bit_sync #(
    parameter int MOD = 16              // legal range 2..16
) (
    input  logic                      clk,
    input  logic                      clr,
    downcounter_4_bit_sync_if.slave   bus
);
    localparam logic [3:0] MAXV = 4'(MOD - 1);

    logic [3:0] r_count;
    logic [3:0] r_reload;
    logic       r_bo;
    logic [3:0] w_load_val;
    logic       w_tc;

    // Load values above the top of the sequence saturate, keeping count < MOD.
    assign w_load_val = (bus.d > MAXV) ? MAXV : bus.d;

    // Underflow is only possible when no higher-priority control is active.
    assign w_tc = (r_count == 4'd0) && bus.en && !(clr || bus.pre || bus.load);

    // Priority: clr > pre > load > en > hold; bo marks the edge that underflowed.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_count  <= 4'd0;
            r_reload <= MAXV;
            r_bo     <= 1'b0;
        end else if (bus.pre) begin
            r_count  <= MAXV;
            r_bo     <= 1'b0;
        end else if (bus.load) begin
            r_count  <= w_load_val;
            r_reload <= w_load_val;
            r_bo     <= 1'b0;
        end else if (bus.en) begin
            if (r_count == 4'd0) begin
                r_count <= bus.auto_reload ? r_reload : MAXV;
                r_bo    <= 1'b1;
            end else begin
                r_count <= r_count - 4'd1;
                r_bo    <= 1'b0;
            end
        end else begin
            r_bo <= 1'b0;
        end
    end

    assign bus.Q0     = r_count[0];
    assign bus.Q1     = r_count[1];
    assign bus.Q2     = r_count[2];
    assign bus.Q3     = r_count[3];
    assign bus.Q0_bar = ~r_count[0];
    assign bus.Q1_bar = ~r_count[1];
    assign bus.Q2_bar = ~r_count[2];
    assign bus.Q3_bar = ~r_count[3];
    assign bus.tc     = w_tc;
    assign bus.bo     = r_bo;
endmodule
